adder_tree_csa_serial: RTL

ADDER_TREE_CSA_SERIAL -- requirements
Module: adder_tree_csa_serial

---
 rtl/adder_tree_csa_serial.sv | 91 +++++++++
 1 files changed

// File: rtl/adder_tree_csa_serial.sv
// Serial frame adder: accumulates I_DATA_N unsigned words in carry-save form,
// resolves the sum with one carry-propagate add, then holds it for downstream.
module adder_tree_csa_serial #(
   parameter int unsigned I_DATA_W = 3,
   parameter int unsigned I_DATA_N = 8
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [I_DATA_W-1:0]                       i_data,
   input  logic                                      i_valid,
   output logic                                      o_ready,
   output logic [I_DATA_W+$clog2(I_DATA_N)-1:0]      o_data,
   output logic                                      o_valid,
   input  logic                                      i_ready
);

   localparam int unsigned O_DATA_W = I_DATA_W + $clog2(I_DATA_N);
   localparam int unsigned CNT_W    = $clog2(I_DATA_N);

   localparam logic [1:0] ACC     = 2'd0;
   localparam logic [1:0] RESOLVE = 2'd1;
   localparam logic [1:0] OUT     = 2'd2;

   logic [1:0]          state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [O_DATA_W-1:0] s, s_nxt;
   logic [O_DATA_W-1:0] c, c_nxt;
   logic [O_DATA_W-1:0] data_nxt;
   logic [O_DATA_W-1:0] d_ext;

   assign d_ext = O_DATA_W'(i_data);

   // State, carry-save accumulator and registered output decodes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ACC;
         cnt     <= '0;
         s       <= '0;
         c       <= '0;
         o_data  <= '0;
         o_valid <= 1'b0;
         o_ready <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         s       <= s_nxt;
         c       <= c_nxt;
         o_data  <= data_nxt;
         o_valid <= (state_nxt == OUT);
         o_ready <= (state_nxt == ACC);
      end
   end

   // Next-state and datapath; carry is kept pre-shifted to its true weight
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      s_nxt     = s;
      c_nxt     = c;
      data_nxt  = o_data;
      case (state)
         ACC: begin
            if (i_valid && o_ready) begin
               s_nxt = s ^ c ^ d_ext;
               c_nxt = ((s & c) | (s & d_ext) | (c & d_ext)) << 1;
               if (cnt == CNT_W'(I_DATA_N - 1)) begin
                  cnt_nxt   = '0;
                  state_nxt = RESOLVE;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         RESOLVE: begin
            data_nxt  = s + c;
            state_nxt = OUT;
         end
         OUT: begin
            if (i_ready) begin
               s_nxt     = '0;
               c_nxt     = '0;
               state_nxt = ACC;
            end
         end
         default: begin
            state_nxt = ACC;
         end
      endcase
   end

endmodule
